multicycle_cu: RTL and testbench



---
 rtl/cu_pkg.sv | 151 +++++++++++++++
 rtl/cu_stall_counter.sv | 27 ++
 rtl/multicycle_cu.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_cu.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcode/func codes,
// the ALU operation encoding, FSM states and the instruction-class decoder.
package cu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // Branch ops make the ALU raise its zero flag exactly when the branch is taken.
    localparam int ALU_OP_BITS = 5;
    localparam logic [ALU_OP_BITS-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALU_OP_BITS-1:0] ALU_SUB   = 5'd1;
    localparam logic [ALU_OP_BITS-1:0] ALU_AND   = 5'd2;
    localparam logic [ALU_OP_BITS-1:0] ALU_OR    = 5'd3;
    localparam logic [ALU_OP_BITS-1:0] ALU_XOR   = 5'd4;
    localparam logic [ALU_OP_BITS-1:0] ALU_NOR   = 5'd5;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLT   = 5'd6;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLTU  = 5'd7;
    localparam logic [ALU_OP_BITS-1:0] ALU_SLL   = 5'd8;
    localparam logic [ALU_OP_BITS-1:0] ALU_SRL   = 5'd9;
    localparam logic [ALU_OP_BITS-1:0] ALU_SRA   = 5'd10;
    localparam logic [ALU_OP_BITS-1:0] ALU_LUI   = 5'd11;
    localparam logic [ALU_OP_BITS-1:0] ALU_MULT  = 5'd12;
    localparam logic [ALU_OP_BITS-1:0] ALU_MULTU = 5'd13;
    localparam logic [ALU_OP_BITS-1:0] ALU_DIV   = 5'd14;
    localparam logic [ALU_OP_BITS-1:0] ALU_DIVU  = 5'd15;
    localparam logic [ALU_OP_BITS-1:0] ALU_BNE   = 5'd16;
    localparam logic [ALU_OP_BITS-1:0] ALU_BLEZ  = 5'd17;
    localparam logic [ALU_OP_BITS-1:0] ALU_BGTZ  = 5'd18;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MULDIV, MEM, WB, HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW, CLS_BRANCH,
        CLS_J, CLS_JAL, CLS_JR, CLS_MULDIV, CLS_SYSCALL
    } instr_class_t;

    typedef struct packed {
        instr_class_t                 cls;
        logic [ALU_OP_BITS-1:0]       alu_op;
        logic                         alu_src;
    } decode_t;

    typedef struct packed {
        logic                   pc_en;
        logic                   ir_en;
        logic                   mem_read;
        logic                   mem_write;
        logic                   iord;
        logic                   reg_write;
        logic                   reg_dest;
        logic                   link;
        logic                   mem_to_reg;
        logic                   alu_src;
        logic [ALU_OP_BITS-1:0] alu_op;
        logic [1:0]             pc_src;
        logic                   illegal;
        logic                   busy;
    } ctl_t;

    function automatic decode_t decode_instr(input logic [5:0] opcode, input logic [5:0] func);
        decode_t d;
        d.cls     = CLS_ILLEGAL;
        d.alu_op  = ALU_ADD;
        d.alu_src = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                d.cls = CLS_ALU_R;
                case (func)
                    FN_ADD, FN_ADDU: d.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: d.alu_op = ALU_SUB;
                    FN_AND:          d.alu_op = ALU_AND;
                    FN_OR:           d.alu_op = ALU_OR;
                    FN_XOR:          d.alu_op = ALU_XOR;
                    FN_NOR:          d.alu_op = ALU_NOR;
                    FN_SLT:          d.alu_op = ALU_SLT;
                    FN_SLTU:         d.alu_op = ALU_SLTU;
                    FN_SLL:          d.alu_op = ALU_SLL;
                    FN_SRL:          d.alu_op = ALU_SRL;
                    FN_SRA:          d.alu_op = ALU_SRA;
                    FN_JR:           d.cls    = CLS_JR;
                    FN_SYSCALL:      d.cls    = CLS_SYSCALL;
                    FN_MULT:  begin d.cls = CLS_MULDIV; d.alu_op = ALU_MULT;  end
                    FN_MULTU: begin d.cls = CLS_MULDIV; d.alu_op = ALU_MULTU; end
                    FN_DIV:   begin d.cls = CLS_MULDIV; d.alu_op = ALU_DIV;   end
                    FN_DIVU:  begin d.cls = CLS_MULDIV; d.alu_op = ALU_DIVU;  end
                    default:         d.cls    = CLS_ILLEGAL;
                endcase
            end
            OP_J:    d.cls = CLS_J;
            OP_JAL:  d.cls = CLS_JAL;
            OP_BEQ:  begin d.cls = CLS_BRANCH; d.alu_op = ALU_SUB;  end
            OP_BNE:  begin d.cls = CLS_BRANCH; d.alu_op = ALU_BNE;  end
            OP_BLEZ: begin d.cls = CLS_BRANCH; d.alu_op = ALU_BLEZ; end
            OP_BGTZ: begin d.cls = CLS_BRANCH; d.alu_op = ALU_BGTZ; end
            OP_ADDI, OP_ADDIU: begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; end
            OP_SLTI:  begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; d.alu_op = ALU_SLT;  end
            OP_SLTIU: begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; d.alu_op = ALU_SLTU; end
            OP_ANDI:  begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; d.alu_op = ALU_AND;  end
            OP_ORI:   begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; d.alu_op = ALU_OR;   end
            OP_XORI:  begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; d.alu_op = ALU_XOR;  end
            OP_LUI:   begin d.cls = CLS_ALU_I; d.alu_src = 1'b1; d.alu_op = ALU_LUI;  end
            OP_LW:    begin d.cls = CLS_LW;    d.alu_src = 1'b1; end
            OP_SW:    begin d.cls = CLS_SW;    d.alu_src = 1'b1; end
            default:  d.cls = CLS_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cu_stall_counter.sv
// Loadable down-counter that times the MULT/DIV stall; done is high at zero.
module cu_stall_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MULDIV/MEM/WB sequencer.
// Optional macro SYSCALL_HALT_EN makes SYSCALL enter a terminal HALT state.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int ALU_OP_W      = 5,
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                pc_en,
    output logic                ir_en,
    output logic                mem_read,
    output logic                mem_write,
    output logic                iord,
    output logic                reg_write,
    output logic                reg_dest,
    output logic                link,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_src,
    output logic                illegal,
    output logic                busy
);

    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] opcode_lat;
    logic [5:0] func_lat;
    decode_t    dinfo;
    ctl_t       ctl;
    ctl_t       ctl_out;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_done;
    logic       instr_unused;

    assign instr_unused = ^instr[25:6];
    assign dinfo        = decode_instr(opcode_lat, func_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_lat <= '0;
            func_lat   <= '0;
        end else if (ctl.ir_en) begin
            opcode_lat <= instr[31:26];
            func_lat   <= instr[5:0];
        end
    end

    cu_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (MULDIV_LOAD),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_comb begin
        ctl        = '0;
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            FETCH: begin
                ctl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctl.ir_en  = 1'b1;
                    ctl.pc_en  = 1'b1;
                    ctl.pc_src = PC_SRC_SEQ;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                ctl.busy   = 1'b1;
                state_next = FETCH;
                case (dinfo.cls)
                    CLS_ILLEGAL: ctl.illegal = 1'b1;
                    CLS_J: begin
                        ctl.pc_en  = 1'b1;
                        ctl.pc_src = PC_SRC_JUMP;
                    end
                    CLS_JAL: begin
                        ctl.pc_en     = 1'b1;
                        ctl.pc_src    = PC_SRC_JUMP;
                        ctl.reg_write = 1'b1;
                        ctl.link      = 1'b1;
                    end
                    CLS_JR: begin
                        ctl.pc_en  = 1'b1;
                        ctl.pc_src = PC_SRC_RS;
                    end
                    CLS_SYSCALL: begin
`ifdef SYSCALL_HALT_EN
                        state_next = HALT;
`else
                        state_next = FETCH;
`endif
                    end
                    default: state_next = EXEC;
                endcase
            end
            EXEC: begin
                ctl.busy    = 1'b1;
                ctl.alu_op  = dinfo.alu_op;
                ctl.alu_src = dinfo.alu_src;
                case (dinfo.cls)
                    CLS_BRANCH: begin
                        ctl.pc_src = PC_SRC_BRANCH;
                        ctl.pc_en  = alu_zero;
                        state_next = FETCH;
                    end
                    CLS_LW, CLS_SW: state_next = MEM;
                    CLS_MULDIV: begin
                        cnt_load   = 1'b1;
                        state_next = MULDIV;
                    end
                    default: state_next = WB;
                endcase
            end
            MULDIV: begin
                ctl.busy   = 1'b1;
                ctl.alu_op = dinfo.alu_op;
                if (cnt_done) begin
                    state_next = WB;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            MEM: begin
                ctl.busy      = 1'b1;
                ctl.iord      = 1'b1;
                ctl.mem_read  = (dinfo.cls == CLS_LW);
                ctl.mem_write = (dinfo.cls == CLS_SW);
                if (mem_ready) begin
                    state_next = (dinfo.cls == CLS_LW) ? WB : FETCH;
                end
            end
            WB: begin
                ctl.busy       = 1'b1;
                ctl.reg_write  = 1'b1;
                ctl.reg_dest   = (opcode_lat == OP_RTYPE);
                ctl.mem_to_reg = (dinfo.cls == CLS_LW);
                state_next     = FETCH;
            end
            HALT: begin
                ctl.busy   = 1'b1;
                state_next = HALT;
            end
            default: state_next = FETCH;
        endcase
    end

    // Reset silences every output at once, including the FETCH read request.
    assign ctl_out = rst_n ? ctl : '0;

    assign pc_en      = ctl_out.pc_en;
    assign ir_en      = ctl_out.ir_en;
    assign mem_read   = ctl_out.mem_read;
    assign mem_write  = ctl_out.mem_write;
    assign iord       = ctl_out.iord;
    assign reg_write  = ctl_out.reg_write;
    assign reg_dest   = ctl_out.reg_dest;
    assign link       = ctl_out.link;
    assign mem_to_reg = ctl_out.mem_to_reg;
    assign alu_src    = ctl_out.alu_src;
    assign alu_op     = ALU_OP_W'(ctl_out.alu_op);
    assign pc_src     = ctl_out.pc_src;
    assign illegal    = ctl_out.illegal;
    assign busy       = ctl_out.busy;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: vector table, directed corner cases,
// and randomized instruction streams checked against a per-phase reference model.
module tb_multicycle_cu;
    import cu_pkg::*;

    localparam int MDC = 5;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        alu_zero;
    logic        pc_en, ir_en, mem_read, mem_write, iord, reg_write, reg_dest;
    logic        link, mem_to_reg, alu_src, illegal, busy;
    logic [4:0]  alu_op;
    logic [1:0]  pc_src;

    multicycle_cu #(
        .ALU_OP_W      (5),
        .MULDIV_CYCLES (MDC),
        .CNT_W         (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .mem_ready  (mem_ready),
        .alu_zero   (alu_zero),
        .pc_en      (pc_en),
        .ir_en      (ir_en),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dest   (reg_dest),
        .link       (link),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dest;
        logic       link;
        logic       mem_to_reg;
        logic       alu_src;
        logic [4:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       busy;
    } outs_t;

    outs_t act;
    assign act = {pc_en, ir_en, mem_read, mem_write, iord, reg_write, reg_dest, link,
                  mem_to_reg, alu_src, alu_op, pc_src, illegal, busy};

    typedef enum logic [3:0] {K_ILL, K_ALUR, K_ALUI, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_MD, K_SYS} kind_t;
    typedef struct packed {
        kind_t      kind;
        logic [4:0] alu;
        logic       src;
    } tb_dec_t;

    typedef struct {
        string       name;
        logic [31:0] iw;
        logic        az;
        int          cycles;
        logic [4:0]  alu3;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_iw   = '0;
    vec_t        vecs[16];

    logic [5:0] op_pool [16] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
    logic [5:0] fn_pool [19] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic outs_t idle_fetch();
        outs_t e = '0;
        e.mem_read = 1'b1;
        return e;
    endfunction

    // Instruction semantics as listed in the MIPS reference tables.
    function automatic tb_dec_t tb_decode(input logic [31:0] iw);
        tb_dec_t    r;
        logic [5:0] op;
        logic [5:0] fn;
        op = iw[31:26];
        fn = iw[5:0];
        r  = '{K_ILL, ALU_ADD, 1'b0};
        if (op == 6'h00) begin
            case (fn)
                6'h20, 6'h21: r = '{K_ALUR, ALU_ADD, 1'b0};
                6'h22, 6'h23: r = '{K_ALUR, ALU_SUB, 1'b0};
                6'h24: r = '{K_ALUR, ALU_AND, 1'b0};
                6'h25: r = '{K_ALUR, ALU_OR, 1'b0};
                6'h26: r = '{K_ALUR, ALU_XOR, 1'b0};
                6'h27: r = '{K_ALUR, ALU_NOR, 1'b0};
                6'h2A: r = '{K_ALUR, ALU_SLT, 1'b0};
                6'h2B: r = '{K_ALUR, ALU_SLTU, 1'b0};
                6'h00: r = '{K_ALUR, ALU_SLL, 1'b0};
                6'h02: r = '{K_ALUR, ALU_SRL, 1'b0};
                6'h03: r = '{K_ALUR, ALU_SRA, 1'b0};
                6'h08: r = '{K_JR, ALU_ADD, 1'b0};
                6'h0C: r = '{K_SYS, ALU_ADD, 1'b0};
                6'h18: r = '{K_MD, ALU_MULT, 1'b0};
                6'h19: r = '{K_MD, ALU_MULTU, 1'b0};
                6'h1A: r = '{K_MD, ALU_DIV, 1'b0};
                6'h1B: r = '{K_MD, ALU_DIVU, 1'b0};
                default: r = '{K_ILL, ALU_ADD, 1'b0};
            endcase
        end else begin
            case (op)
                6'h02: r = '{K_J, ALU_ADD, 1'b0};
                6'h03: r = '{K_JAL, ALU_ADD, 1'b0};
                6'h04: r = '{K_BR, ALU_SUB, 1'b0};
                6'h05: r = '{K_BR, ALU_BNE, 1'b0};
                6'h06: r = '{K_BR, ALU_BLEZ, 1'b0};
                6'h07: r = '{K_BR, ALU_BGTZ, 1'b0};
                6'h08, 6'h09: r = '{K_ALUI, ALU_ADD, 1'b1};
                6'h0A: r = '{K_ALUI, ALU_SLT, 1'b1};
                6'h0B: r = '{K_ALUI, ALU_SLTU, 1'b1};
                6'h0C: r = '{K_ALUI, ALU_AND, 1'b1};
                6'h0D: r = '{K_ALUI, ALU_OR, 1'b1};
                6'h0E: r = '{K_ALUI, ALU_XOR, 1'b1};
                6'h0F: r = '{K_ALUI, ALU_LUI, 1'b1};
                6'h23: r = '{K_LW, ALU_ADD, 1'b1};
                6'h2B: r = '{K_SW, ALU_ADD, 1'b1};
                default: r = '{K_ILL, ALU_ADD, 1'b0};
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s instr=%h: got %h want %h", name, cur_iw, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s instr=%h: got %0d want %0d", name, cur_iw, got, exp);
        end
    endtask

    task automatic step(input string name, input outs_t exp, input logic mr,
                        input logic [31:0] iw, input logic az);
        @(negedge clk);
        mem_ready = mr;
        instr     = iw;
        alu_zero  = az;
        #1;
        check(name, act, exp);
    endtask

    // Reference model: walks the instruction through its phases and checks each cycle.
    task automatic run_model(input logic [31:0] iw, input int fwait, input int mwait, input logic az);
        tb_dec_t d;
        outs_t   e;
        d      = tb_decode(iw);
        cur_iw = iw;
        for (int i = 0; i < fwait; i++) step("fetch_wait", idle_fetch(), 1'b0, $urandom, rbit());
        e = idle_fetch();
        e.ir_en = 1'b1;
        e.pc_en = 1'b1;
        step("fetch", e, 1'b1, iw, rbit());

        e = '0;
        e.busy = 1'b1;
        case (d.kind)
            K_ILL: e.illegal = 1'b1;
            K_J:   begin e.pc_en = 1'b1; e.pc_src = 2'd2; end
            K_JAL: begin e.pc_en = 1'b1; e.pc_src = 2'd2; e.reg_write = 1'b1; e.link = 1'b1; end
            K_JR:  begin e.pc_en = 1'b1; e.pc_src = 2'd3; end
            default: ;
        endcase
        step("decode", e, rbit(), $urandom, rbit());
        if (d.kind inside {K_ILL, K_J, K_JAL, K_JR, K_SYS}) return;

        e = '0;
        e.busy    = 1'b1;
        e.alu_op  = d.alu;
        e.alu_src = d.src;
        if (d.kind == K_BR) begin
            e.pc_src = 2'd1;
            e.pc_en  = az;
        end
        step("exec", e, rbit(), $urandom, az);
        if (d.kind == K_BR) return;

        if (d.kind == K_MD) begin
            for (int i = 0; i < MDC; i++) begin
                e = '0;
                e.busy   = 1'b1;
                e.alu_op = d.alu;
                step("muldiv", e, rbit(), $urandom, rbit());
            end
        end

        if (d.kind == K_LW || d.kind == K_SW) begin
            e = '0;
            e.busy      = 1'b1;
            e.iord      = 1'b1;
            e.mem_read  = (d.kind == K_LW);
            e.mem_write = (d.kind == K_SW);
            for (int i = 0; i < mwait; i++) step("mem_wait", e, 1'b0, $urandom, rbit());
            step("mem_done", e, 1'b1, $urandom, rbit());
            if (d.kind == K_SW) return;
        end

        e = '0;
        e.busy       = 1'b1;
        e.reg_write  = 1'b1;
        e.reg_dest   = (iw[31:26] == 6'h00);
        e.mem_to_reg = (d.kind == K_LW);
        step("wb", e, rbit(), $urandom, rbit());
    endtask

    task automatic set_vec(input int i, input string name, input logic [31:0] iw,
                           input logic az, input int cyc, input logic [4:0] alu3);
        vecs[i].name   = name;
        vecs[i].iw     = iw;
        vecs[i].az     = az;
        vecs[i].cycles = cyc;
        vecs[i].alu3   = alu3;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t       e;
        logic [31:0] iw;
        int          n;
        logic        done;
        logic [4:0]  alu3;

        set_vec(0,  "add",    32'h012A_4020, 1'b0, 4, ALU_ADD);
        set_vec(1,  "addi",   32'h2128_0005, 1'b0, 4, ALU_ADD);
        set_vec(2,  "lw",     32'h8D28_0004, 1'b0, 5, ALU_ADD);
        set_vec(3,  "sw",     32'hAD28_0004, 1'b0, 4, ALU_ADD);
        set_vec(4,  "beq",    32'h1109_0003, 1'b1, 3, ALU_SUB);
        set_vec(5,  "bne",    32'h1509_0003, 1'b0, 3, ALU_BNE);
        set_vec(6,  "j",      32'h0800_0010, 1'b0, 2, ALU_ADD);
        set_vec(7,  "jal",    32'h0C00_0010, 1'b0, 2, ALU_ADD);
        set_vec(8,  "jr",     32'h03E0_0008, 1'b0, 2, ALU_ADD);
        set_vec(9,  "mult",   32'h0109_0018, 1'b0, 4 + MDC, ALU_MULT);
        set_vec(10, "divu",   32'h0109_001B, 1'b0, 4 + MDC, ALU_DIVU);
        set_vec(11, "ill_op", 32'hFC00_0000, 1'b0, 2, ALU_ADD);
        set_vec(12, "ill_fn", 32'h0109_003F, 1'b0, 2, ALU_ADD);
        set_vec(13, "lui",    32'h3C08_1234, 1'b0, 4, ALU_LUI);
        set_vec(14, "slti",   32'h2928_0005, 1'b0, 4, ALU_SLT);
        set_vec(15, "ori",    32'h3528_00FF, 1'b0, 4, ALU_OR);

        rst_n     = 1'b0;
        mem_ready = 1'b1;
        instr     = 32'h012A_4020;
        alu_zero  = 1'b0;
        #1;
        check("reset_state", act, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("fetch_after_reset", act, idle_fetch());

        // Vector table: cycle count to return to FETCH and alu_op in cycle 3.
        for (int v = 0; v < 16; v++) begin
            cur_iw = vecs[v].iw;
            @(negedge clk);
            instr     = vecs[v].iw;
            mem_ready = 1'b1;
            alu_zero  = vecs[v].az;
            n         = 1;
            done      = 1'b0;
            alu3      = '0;
            while (!done && n < 60) begin
                @(negedge clk);
                n++;
                if (!busy) begin
                    mem_ready = 1'b0;
                    done      = 1'b1;
                end else begin
                    mem_ready = 1'b1;
                end
                instr = $urandom;
                #1;
                if (n == 3) alu3 = act.alu_op;
            end
            check_int({vecs[v].name, "_cycles"}, n - 1, vecs[v].cycles);
            check_int({vecs[v].name, "_alu_op"}, int'(alu3), int'(vecs[v].alu3));
        end

        // Directed sequences.
        run_model(32'h012A_4020, 0, 0, 1'b0);
        run_model(32'h8D28_0004, 0, 3, 1'b0);
        run_model(32'h1109_0003, 0, 0, 1'b1);
        run_model(32'h1109_0003, 0, 0, 1'b0);
        run_model(32'h0109_0018, 0, 0, 1'b0);
        run_model(32'hFC00_0000, 0, 0, 1'b0);
        step("after_illegal", idle_fetch(), 1'b0, $urandom, 1'b0);
        run_model(32'h0C00_0010, 2, 0, 1'b0);
        run_model(32'hAD28_0004, 1, 0, 1'b0);

        // Reset lands while a store is waiting in MEM.
        iw     = 32'hAD28_0010;
        cur_iw = iw;
        e = idle_fetch();
        e.ir_en = 1'b1;
        e.pc_en = 1'b1;
        step("rst_sw_fetch", e, 1'b1, iw, 1'b0);
        e = '0;
        e.busy = 1'b1;
        step("rst_sw_decode", e, 1'b0, $urandom, 1'b0);
        e.alu_op  = ALU_ADD;
        e.alu_src = 1'b1;
        step("rst_sw_exec", e, 1'b0, $urandom, 1'b0);
        e = '0;
        e.busy      = 1'b1;
        e.iord      = 1'b1;
        e.mem_write = 1'b1;
        step("rst_sw_mem", e, 1'b0, $urandom, 1'b0);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_abort", act, '0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rst_release", act, idle_fetch());
        step("rst_hold", idle_fetch(), 1'b0, $urandom, 1'b0);

`ifdef SYSCALL_HALT_EN
        cur_iw = 32'h0000_000C;
        e = idle_fetch();
        e.ir_en = 1'b1;
        e.pc_en = 1'b1;
        step("sys_fetch", e, 1'b1, 32'h0000_000C, 1'b0);
        e = '0;
        e.busy = 1'b1;
        step("sys_decode", e, 1'b1, $urandom, 1'b0);
        for (int i = 0; i < 4; i++) step("halt", e, 1'b1, $urandom, rbit());
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("halt_exit", act, idle_fetch());
`else
        run_model(32'h0000_000C, 0, 0, 1'b0);
        step("after_syscall", idle_fetch(), 1'b0, $urandom, 1'b0);
`endif

        // Randomized instruction stream.
        for (int k = 0; k < 250; k++) begin
            iw = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    iw[31:26] = 6'h00;
                    iw[5:0]   = fn_pool[$urandom_range(0, 18)];
                end
                4, 5, 6, 7, 8: iw[31:26] = op_pool[$urandom_range(0, 15)];
                default: ;
            endcase
`ifdef SYSCALL_HALT_EN
            if (tb_decode(iw).kind == K_SYS) iw[5:0] = 6'h20;
`endif
            run_model(iw, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
        end
        step("final_idle", idle_fetch(), 1'b0, $urandom, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
